hvac_seq_ctrl: RTL and testbench

- Sequences the HVAC relays (heat, cool, fan) from the active 32-bit STC word and the measured temperature.
- The STC word comes from the manual/override path or the scheduler.
- Enforces fan lead/trail times, a minimum on-time and a minimum off-time (short-cycle lockout).
- Sits between the user-control/override block and the relay output drivers.

---
 rtl/hvac_pkg.sv | 38 +++
 rtl/hvac_seq_ctrl_timer.sv | 48 ++++
 rtl/hvac_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_hvac_seq_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// hvac_pkg: shared types and constants for the HVAC relay sequencer.
//   - FSM state encoding (also driven out on o_state)
//   - STC word field positions
//   - timer width helper and setpoint scaling helper
package hvac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COOL_PRE = 3'd1,
    ST_HEAT     = 3'd2,
    ST_COOL     = 3'd3,
    ST_FAN_POST = 3'd4
  } hvac_state_t;

  localparam int c_stc_heat_bit   = 18;
  localparam int c_stc_cool_bit   = 17;
  localparam int c_stc_cool_sp_hi = 15;
  localparam int c_stc_cool_sp_lo = 8;
  localparam int c_stc_heat_sp_hi = 7;
  localparam int c_stc_heat_sp_lo = 0;

  // Quarter-degree setpoint width and the widened compare width for +hyst.
  localparam int c_sp_q_w = 10;
  localparam int c_cmp_w  = 11;

  // A timer must hold the longest load: 255 seconds worth of cycles.
  function automatic int timer_width(input int clk_freq);
    return $clog2(clk_freq * 255 + 1);
  endfunction

  localparam int c_timer_w = timer_width(50);

  // Integer degrees -> quarter degrees (matches the ufixed(6 downto -2) temp).
  function automatic logic [9:0] sp_to_q(input logic [7:0] sp);
    return {sp, 2'b00};
  endfunction

endpackage

// File: rtl/hvac_seq_ctrl_timer.sv
// hvac_dn_timer: seconds-loaded, cycle-exact down-counter.
//   clk, reset   : clock, synchronous active-high reset (clears the count)
//   load, load_s : load load_s seconds (converted to load_s * g_clk_freq cycles)
//   en           : count enable; the count holds at 0 once expired
//   expired      : count == 0
//   nonzero      : count != 0
// Loading N seconds makes 'expired' rise exactly N*g_clk_freq edges later.
module hvac_dn_timer
  import hvac_pkg::*;
#(
  parameter int g_clk_freq = 50,
  parameter int g_w        = timer_width(g_clk_freq)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_s,
  input  logic       en,
  output logic       expired,
  output logic       nonzero
);

  localparam logic [g_w-1:0] c_freq = g_w'(g_clk_freq);
  localparam logic [g_w-1:0] c_zero = {g_w{1'b0}};
  localparam logic [g_w-1:0] c_one  = g_w'(1);

  logic [g_w-1:0] count_r;
  logic [g_w-1:0] load_val_s;

  assign load_val_s = g_w'(load_s) * c_freq;

  // Count register: load has priority, then decrement down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= c_zero;
    end else if (load) begin
      count_r <= load_val_s;
    end else if (en && (count_r != c_zero)) begin
      count_r <= count_r - c_one;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == c_zero);
  assign nonzero = (count_r != c_zero);

endmodule

// File: rtl/hvac_seq_ctrl.sv
// hvac_seq_ctrl: sequences heat/cool/fan relays from the active STC word and
// the measured temperature, with fan lead/trail, minimum on-time and a
// minimum off-time lockout.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_stc[31:0]    : [18] heat en, [17] cool en, [15:8] cool sp, [7:0] heat sp
//   i_temp[8:0]    : measured temperature, quarter degrees
//   o_heat/o_cool/o_fan : registered relay drives
//   o_state[2:0]   : current FSM state
//   o_lockout      : min-off timer running
module hvac_seq_ctrl
  import hvac_pkg::*;
#(
  parameter int g_clk_freq    = 50,
  parameter int g_min_on_s    = 4,
  parameter int g_min_off_s   = 6,
  parameter int g_fan_lead_s  = 2,
  parameter int g_fan_trail_s = 3,
  parameter int g_hyst        = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_stc,
  input  logic [8:0]  i_temp,
  output logic        o_heat,
  output logic        o_cool,
  output logic        o_fan,
  output logic [2:0]  o_state,
  output logic        o_lockout
);

  localparam int c_tw = timer_width(g_clk_freq);
  localparam logic [c_sp_q_w-1:0] c_hyst_q   = c_sp_q_w'(g_hyst);
  localparam logic [c_cmp_w-1:0]  c_hyst_cmp = c_cmp_w'(g_hyst);

  // Fields of the STC word this block does not use.
  logic unused_stc_s;
  assign unused_stc_s = ^{i_stc[31:19], i_stc[16]};

  logic                heat_en_s;
  logic                cool_en_s;
  logic [c_sp_q_w-1:0] heat_sp_q_s;
  logic [c_sp_q_w-1:0] cool_sp_q_s;
  logic [c_sp_q_w-1:0] temp_q_s;
  logic [c_cmp_w-1:0]  heat_clr_s;
  logic [c_sp_q_w-1:0] cool_clr_s;

  assign heat_en_s   = i_stc[c_stc_heat_bit];
  assign cool_en_s   = i_stc[c_stc_cool_bit];
  assign heat_sp_q_s = sp_to_q(i_stc[c_stc_heat_sp_hi:c_stc_heat_sp_lo]);
  assign cool_sp_q_s = sp_to_q(i_stc[c_stc_cool_sp_hi:c_stc_cool_sp_lo]);
  assign temp_q_s    = {1'b0, i_temp};
  assign heat_clr_s  = {1'b0, heat_sp_q_s} + c_hyst_cmp;
  // Cool clear threshold floors at 0 instead of wrapping.
  assign cool_clr_s  = (cool_sp_q_s < c_hyst_q) ? {c_sp_q_w{1'b0}}
                                                : (cool_sp_q_s - c_hyst_q);

  logic heat_dem_r, heat_dem_nxt;
  logic cool_dem_r, cool_dem_nxt;

  // Heat demand with hysteresis: set below setpoint, clear at setpoint + hyst.
  always_comb begin
    heat_dem_nxt = heat_dem_r;
    if (!heat_en_s) begin
      heat_dem_nxt = 1'b0;
    end else if (temp_q_s < heat_sp_q_s) begin
      heat_dem_nxt = 1'b1;
    end else if ({1'b0, temp_q_s} >= heat_clr_s) begin
      heat_dem_nxt = 1'b0;
    end else begin
      heat_dem_nxt = heat_dem_r;
    end
  end

  // Cool demand with hysteresis: set above setpoint, clear at setpoint - hyst.
  always_comb begin
    cool_dem_nxt = cool_dem_r;
    if (!cool_en_s) begin
      cool_dem_nxt = 1'b0;
    end else if (temp_q_s > cool_sp_q_s) begin
      cool_dem_nxt = 1'b1;
    end else if (temp_q_s <= cool_clr_s) begin
      cool_dem_nxt = 1'b0;
    end else begin
      cool_dem_nxt = cool_dem_r;
    end
  end

  // Demand flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      heat_dem_r <= 1'b0;
      cool_dem_r <= 1'b0;
    end else begin
      heat_dem_r <= heat_dem_nxt;
      cool_dem_r <= cool_dem_nxt;
    end
  end

  // Timers.
  logic       st_load_s;
  logic [7:0] st_load_val_s;
  logic       st_expired_s;
  logic       st_nonzero_s;
  logic       lo_load_s;
  logic       lo_expired_s;
  logic       lo_nonzero_s;

  hvac_dn_timer #(.g_clk_freq(g_clk_freq), .g_w(c_tw)) u_state_timer (
    .clk     (i_clk),
    .reset   (i_reset),
    .load    (st_load_s),
    .load_s  (st_load_val_s),
    .en      (1'b1),
    .expired (st_expired_s),
    .nonzero (st_nonzero_s)
  );

  hvac_dn_timer #(.g_clk_freq(g_clk_freq), .g_w(c_tw)) u_lockout_timer (
    .clk     (i_clk),
    .reset   (i_reset),
    .load    (lo_load_s),
    .load_s  (8'(g_min_off_s)),
    .en      (1'b1),
    .expired (lo_expired_s),
    .nonzero (lo_nonzero_s)
  );

  logic unused_timer_s;
  assign unused_timer_s = st_nonzero_s;

  hvac_state_t state_r, state_nxt;
  logic        heat_go_s;
  logic        cool_go_s;
  logic        heat_nxt, cool_nxt, fan_nxt;

  // Enable bits gate the registered demands so a cleared STC word never
  // starts or extends a cycle while the demand flag is still catching up.
  assign heat_go_s = heat_dem_r && heat_en_s;
  assign cool_go_s = cool_dem_r && cool_en_s && !heat_go_s;

  // Next-state and timer-load decisions.
  always_comb begin
    state_nxt     = state_r;
    st_load_s     = 1'b0;
    st_load_val_s = 8'd0;
    lo_load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (heat_go_s && lo_expired_s) begin
          state_nxt     = ST_HEAT;
          st_load_s     = 1'b1;
          st_load_val_s = 8'(g_min_on_s);
        end else if (cool_go_s && lo_expired_s) begin
          state_nxt     = ST_COOL_PRE;
          st_load_s     = 1'b1;
          st_load_val_s = 8'(g_fan_lead_s);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_COOL_PRE: begin
        if (!cool_dem_r || !cool_en_s) begin
          state_nxt     = ST_FAN_POST;
          st_load_s     = 1'b1;
          st_load_val_s = 8'(g_fan_trail_s);
          lo_load_s     = 1'b1;
        end else if (st_expired_s) begin
          state_nxt     = ST_COOL;
          st_load_s     = 1'b1;
          st_load_val_s = 8'(g_min_on_s);
        end else begin
          state_nxt = ST_COOL_PRE;
        end
      end
      ST_HEAT: begin
        if (!heat_en_s || (!heat_dem_r && st_expired_s)) begin
          state_nxt     = ST_FAN_POST;
          st_load_s     = 1'b1;
          st_load_val_s = 8'(g_fan_trail_s);
          lo_load_s     = 1'b1;
        end else begin
          state_nxt = ST_HEAT;
        end
      end
      ST_COOL: begin
        if (!cool_en_s || (!cool_dem_r && st_expired_s)) begin
          state_nxt     = ST_FAN_POST;
          st_load_s     = 1'b1;
          st_load_val_s = 8'(g_fan_trail_s);
          lo_load_s     = 1'b1;
        end else begin
          state_nxt = ST_COOL;
        end
      end
      ST_FAN_POST: begin
        if (st_expired_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_FAN_POST;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Relay decode from the next state so relays switch together with the state.
  always_comb begin
    heat_nxt = 1'b0;
    cool_nxt = 1'b0;
    fan_nxt  = 1'b0;
    case (state_nxt)
      ST_IDLE:     fan_nxt = 1'b0;
      ST_COOL_PRE: fan_nxt = 1'b1;
      ST_HEAT: begin
        heat_nxt = 1'b1;
        fan_nxt  = 1'b1;
      end
      ST_COOL: begin
        cool_nxt = 1'b1;
        fan_nxt  = 1'b1;
      end
      ST_FAN_POST: fan_nxt = 1'b1;
      default: begin
        heat_nxt = 1'b0;
        cool_nxt = 1'b0;
        fan_nxt  = 1'b0;
      end
    endcase
  end

  // State and relay registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      o_heat  <= 1'b0;
      o_cool  <= 1'b0;
      o_fan   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      o_heat  <= heat_nxt;
      o_cool  <= cool_nxt;
      o_fan   <= fan_nxt;
    end
  end

  assign o_state   = state_r;
  assign o_lockout = lo_nonzero_s;

endmodule

// File: tb/tb_hvac_seq_ctrl.sv
// tb_hvac_seq_ctrl: table-driven directed bench for hvac_seq_ctrl.
// Each table row applies inputs, advances n clock edges, then compares all
// outputs. Relay exclusivity is compared after every edge.
module tb_hvac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stc;
  logic [8:0]  temp;
  logic        heat, cool, fan, lockout;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  hvac_seq_ctrl dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_stc     (stc),
    .i_temp    (temp),
    .o_heat    (heat),
    .o_cool    (cool),
    .o_fan     (fan),
    .o_state   (state),
    .o_lockout (lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] stc;
    logic [8:0]  temp;
    int          n;
    logic        heat;
    logic        cool;
    logic        fan;
    logic [2:0]  st;
    logic        lock;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] s, input logic [8:0] t,
                     input int n, input logic h, input logic c, input logic f,
                     input logic [2:0] st, input logic lk);
    vec_t v;
    v.rst = r; v.stc = s; v.temp = t; v.n = n;
    v.heat = h; v.cool = c; v.fan = f; v.st = st; v.lock = lk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (heat === 1'b1 && cool === 1'b1) begin
        errors++;
        $display("FAIL relay_excl actual=heat1_cool1 expected=not_both");
      end
    end
  endtask

  initial begin
    int waited;
    rst  = 1'b1;
    stc  = 32'h0;
    temp = 9'h0;

    // rst, stc, temp, n, heat, cool, fan, state, lockout
    // Reset held, then heat start (sp 28, temp 25).
    add(1'b1, 32'h41F1C, 9'h064,   3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h41F1C, 9'h064,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h41F1C, 9'h064,   1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b0, 32'h41F1C, 9'h064,  49, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    // Demand clears at cycle 50, min-on holds heat to cycle 200.
    add(1'b0, 32'h41F1C, 9'h072, 151, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b0, 32'h41F1C, 9'h072,   1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h41F1C, 9'h072, 150, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h41F1C, 9'h072,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h41F1C, 9'h072, 148, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h41F1C, 9'h072,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h41F1C, 9'h072,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    // Cool: sp 20, temp 21 -> fan lead, then compressor.
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 32'h21412, 9'h054, 100, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    // Temp 19.5 clears cool demand; min-on still applies.
    add(1'b0, 32'h21412, 9'h04E, 200, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    add(1'b0, 32'h21412, 9'h04E,   1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    // Demand back 1 cycle after FAN_POST: wait out trail and lockout.
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h21412, 9'h054, 150, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h21412, 9'h054, 148, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 32'h21412, 9'h054, 100, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    add(1'b0, 32'h21412, 9'h054,   1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    // STC cleared one cycle into COOL: immediate FAN_POST.
    add(1'b0, 32'h00000, 9'h054,   1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h00000, 9'h054, 150, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h00000, 9'h054,   1, 1'b0, 1'b0, 0,    3'd0, 1'b1);
    // Auto both enables: heat first (lockout gated), cool ignored during HEAT.
    add(1'b0, 32'h61816, 9'h054, 148, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h61816, 9'h054,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h61816, 9'h054,   1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b0, 32'h61816, 9'h068, 200, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b0, 32'h61816, 9'h068,   1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h61816, 9'h068, 150, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    add(1'b0, 32'h61816, 9'h068,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h61816, 9'h068, 148, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(1'b0, 32'h61816, 9'h068,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 32'h61816, 9'h068,   1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    // Reset mid-cycle drops everything on the next edge.
    add(1'b1, 32'h61816, 9'h068,   1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    // Cool setpoint 0: clear threshold floors at 0.
    add(1'b0, 32'h20000, 9'h001,   2, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 32'h20000, 9'h000,   1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    add(1'b0, 32'h20000, 9'h000,   1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      stc  = vecs[i].stc;
      temp = vecs[i].temp;
      step(vecs[i].n);
      chk($sformatf("v%0d.heat", i),  {31'd0, heat},    {31'd0, vecs[i].heat});
      chk($sformatf("v%0d.cool", i),  {31'd0, cool},    {31'd0, vecs[i].cool});
      chk($sformatf("v%0d.fan", i),   {31'd0, fan},     {31'd0, vecs[i].fan});
      chk($sformatf("v%0d.state", i), {29'd0, state},   {29'd0, vecs[i].st});
      chk($sformatf("v%0d.lock", i),  {31'd0, lockout}, {31'd0, vecs[i].lock});
    end

    // Just entered FAN_POST: clearing STC must reach IDLE after the trail.
    stc = 32'h0;
    waited = 0;
    while (state !== 3'd0 && waited < 152) begin
      step(1);
      waited++;
    end
    chk("idle_bound_state", {29'd0, state}, 32'd0);
    chk("idle_bound_time", waited, 32'd151);
    chk("idle_bound_fan", {31'd0, fan}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
